// File: rtl/oam_dma_pkg.sv
// Shared bus addresses, transfer length and state type for the OAM DMA engine.
package oam_dma_pkg;

    localparam logic [15:0] DMA_OAM_ADDR = 16'hFF46;
    localparam int          OAM_DMA_LEN  = 160;
    localparam logic [15:0] HRAM_START   = 16'hFF80;
    localparam logic [15:0] HRAM_END     = 16'hFFFE;

    typedef enum logic {
        DMA_IDLE     = 1'b0,
        DMA_TRANSFER = 1'b1
    } dma_state_t;

    // Pages E0-FF mirror C0-DF (echo RAM), so the source is fetched from the mirror.
    function automatic logic [7:0] source_page(input logic [7:0] page);
        return (page >= 8'hE0) ? page - 8'h20 : page;
    endfunction

endpackage

// File: rtl/oam_dma_slot_timer.sv
// Byte-slot sequencer: walks phase within a byte and the byte index across the OAM image.
module oam_dma_slot_timer #(
    parameter  int CYCLES_PER_BYTE = 4,
    parameter  int OAM_BYTES       = 160,
    localparam int PHASE_W         = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               restart,
    output logic [PHASE_W-1:0] phase,
    output logic [7:0]         idx,
    output logic               read_slot,
    output logic               write_slot,
    output logic               last_slot
);

    assign read_slot  = (phase == '0);
    assign write_slot = (phase == PHASE_W'(CYCLES_PER_BYTE - 1));
    assign last_slot  = write_slot && (idx == 8'(OAM_BYTES - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            phase <= '0;
            idx   <= '0;
        end else if (run) begin
            if (write_slot) begin
                phase <= '0;
                idx   <= last_slot ? 8'd0 : idx + 8'd1;
            end else begin
                phase <= phase + PHASE_W'(1);
            end
        end
    end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: FF46 write copies one 160-byte page into OAM.
// Optional OAM_DMA_BUS_CONFLICT_EN flags CPU accesses outside HRAM while a transfer is active.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4,
    parameter int OAM_BYTES       = OAM_DMA_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        src_read_en,
    output logic [15:0] src_addr,
    input  logic [7:0]  src_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        active,
    output logic        cpu_conflict
);

    localparam int DELAY_W = $clog2(START_DELAY + 1);
    localparam int PHASE_W = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;

    dma_state_t         state_q, state_d;
    logic [7:0]         dma_reg, pend_page, cur_page, data_q;
    logic [DELAY_W-1:0] delay_q;
    logic [PHASE_W-1:0] phase;
    logic [7:0]         idx;
    logic               trigger, expire, run;
    logic               read_slot, write_slot, last_slot;

    assign trigger = cpu_write_en && (cpu_addr == DMA_OAM_ADDR);
    // A reload on the final countdown clk postpones the restart instead of firing it.
    assign expire  = !trigger && (delay_q == DELAY_W'(1));
    assign run     = (state_q == DMA_TRANSFER);
    assign active  = run;

    oam_dma_slot_timer #(
        .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
        .OAM_BYTES       (OAM_BYTES)
    ) u_slot_timer (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .restart    (expire),
        .phase      (phase),
        .idx        (idx),
        .read_slot  (read_slot),
        .write_slot (write_slot),
        .last_slot  (last_slot)
    );

    // The pending page is only adopted on delay expiry, so a running transfer keeps its source.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            dma_reg   <= 8'h00;
            pend_page <= 8'h00;
            cur_page  <= 8'h00;
            data_q    <= 8'h00;
            delay_q   <= '0;
        end else begin
            state_q <= state_d;
            if (trigger) begin
                dma_reg   <= cpu_wdata;
                pend_page <= source_page(cpu_wdata);
                delay_q   <= DELAY_W'(START_DELAY);
            end else if (delay_q != '0) begin
                delay_q <= delay_q - DELAY_W'(1);
            end
            if (expire)
                cur_page <= pend_page;
            if (run && read_slot)
                data_q <= src_rdata;
        end
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        src_read_en = 1'b0;
        src_addr    = 16'h0000;
        oam_we      = 1'b0;
        oam_addr    = 8'h00;
        oam_wdata   = 8'h00;

        if (expire)
            state_d = DMA_TRANSFER;
        else if (run && last_slot)
            state_d = DMA_IDLE;

        if (run) begin
            if (read_slot) begin
                src_read_en = 1'b1;
                src_addr    = {cur_page, 8'h00} + 16'(idx);
            end
            if (write_slot) begin
                oam_we    = 1'b1;
                oam_addr  = idx;
                oam_wdata = data_q;
            end
        end
    end

    assign cpu_rdata = (cpu_read_en && (cpu_addr == DMA_OAM_ADDR)) ? dma_reg : 8'hFF;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    assign cpu_conflict = active && (cpu_read_en || cpu_write_en) &&
                          ((cpu_addr < HRAM_START) || (cpu_addr > HRAM_END));
`else
    assign cpu_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: timing, echo remap, restart, reset and bus conflict.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_write_en, cpu_read_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        src_read_en;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr, oam_wdata;
    logic        active, cpu_conflict;

    logic [7:0]  mem [0:65535];
    int          vectors = 0;
    int          miscompares = 0;

`ifdef OAM_DMA_BUS_CONFLICT_EN
    localparam logic CONFLICT_EXP = 1'b1;
`else
    localparam logic CONFLICT_EXP = 1'b0;
`endif

    assign src_rdata = mem[src_addr];

    oam_dma dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_write_en (cpu_write_en),
        .cpu_read_en  (cpu_read_en),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .src_read_en  (src_read_en),
        .src_addr     (src_addr),
        .src_rdata    (src_rdata),
        .oam_we       (oam_we),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .active       (active),
        .cpu_conflict (cpu_conflict)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_write_en = 1'b1;
        cpu_addr     = a;
        cpu_wdata    = d;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_wdata    = 8'h00;
    endtask

    task automatic rd_probe(input logic [15:0] a, output logic [7:0] data, output logic conf);
        cpu_read_en = 1'b1;
        cpu_addr    = a;
        #1;
        data        = cpu_rdata;
        conf        = cpu_conflict;
        cpu_read_en = 1'b0;
        cpu_addr    = 16'h0000;
    endtask

    task automatic wait_we(input logic [7:0] a, input string tag);
        int n = 0;
        while (!(oam_we && oam_addr == a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(oam_we && oam_addr == a), 1);
    endtask

    // Called at the negedge right after the trigger edge (clk 0); "clk k+1" is the edge committing what is seen at negedge k.
    task automatic run_transfer(input logic [7:0] key,
                                output int first_clk, output int first_addr, output int first_data,
                                output int last_addr, output int last_data, output int strobes,
                                output int active_cycles, output int fall_clk, output int data_errs,
                                output int first_src);
        int   k    = 0;
        logic seen = 1'b0;
        first_clk = -1; first_addr = -1; first_data = -1; last_addr = -1; last_data = -1;
        strobes = 0; active_cycles = 0; fall_clk = -1; data_errs = 0; first_src = -1;
        while (k < 1500) begin
            if (src_read_en && first_src < 0)
                first_src = int'(src_addr);
            if (oam_we) begin
                if (strobes == 0) begin
                    first_clk  = k + 1;
                    first_addr = int'(oam_addr);
                    first_data = int'(oam_wdata);
                end
                strobes++;
                last_addr = int'(oam_addr);
                last_data = int'(oam_wdata);
                if (oam_wdata !== (oam_addr ^ key))
                    data_errs++;
            end
            if (active) begin
                active_cycles++;
                seen = 1'b1;
            end else if (seen) begin
                fall_clk = k + 1;
                break;
            end
            @(negedge clk);
            k++;
        end
    endtask

    task automatic watch_restart(input logic [7:0] key,
                                 output int last_old, output int gap, output int new_strobes,
                                 output int last_new_addr, output int first_new_data,
                                 output int dropped, output int data_errs);
        int   rel     = 0;
        logic started = 1'b0;
        last_old = -1; gap = -1; new_strobes = 0; last_new_addr = -1;
        first_new_data = -1; dropped = 0; data_errs = 0;
        while (rel < 1500) begin
            if (oam_we) begin
                if (!started && oam_addr == 8'h00) begin
                    started        = 1'b1;
                    gap            = rel + 1;
                    first_new_data = int'(oam_wdata);
                end
                if (started) begin
                    new_strobes++;
                    last_new_addr = int'(oam_addr);
                    if (oam_wdata !== (oam_addr ^ key))
                        data_errs++;
                end else begin
                    last_old = int'(oam_addr);
                end
            end
            if (!active) begin
                if (!started)
                    dropped = 1;
                break;
            end
            @(negedge clk);
            rel++;
        end
    endtask

    initial begin
        int   f_clk, f_addr, f_data, l_addr, l_data, n_strb, a_cyc, fall, errs, f_src;
        int   l_old, gap, n_new, l_new, f_new, drop;
        int   n;
        logic [7:0] rd;
        logic       conf;

        for (int i = 0; i < 256; i++) begin
            mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hD000 + 16'(i)] = 8'(i) ^ 8'hA5;
            mem[16'hC300 + 16'(i)] = 8'(i);
        end

        reset        = 1'b1;
        cpu_write_en = 1'b0;
        cpu_read_en  = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_wdata    = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_active",      32'(active), 0);
        chk("rst_oam_we",      32'(oam_we), 0);
        chk("rst_src_read_en", 32'(src_read_en), 0);
        chk("rst_src_addr",    32'(src_addr), 0);
        chk("rst_oam_addr",    32'(oam_addr), 0);
        chk("rst_oam_wdata",   32'(oam_wdata), 0);
        chk("rst_cpu_rdata",   32'(cpu_rdata), 32'hFF);
        chk("rst_conflict",    32'(cpu_conflict), 0);
        rd_probe(16'hFF46, rd, conf);
        chk("rst_ff46_read", 32'(rd), 32'h00);

        // Plain transfer from page C1
        cpu_wr(16'hFF46, 8'hC1);
        run_transfer(8'h5A, f_clk, f_addr, f_data, l_addr, l_data, n_strb, a_cyc, fall, errs, f_src);
        chk("c1_first_src_addr",  32'(f_src), 32'hC100);
        chk("c1_first_we_clk",    32'(f_clk), 8);
        chk("c1_first_addr",      32'(f_addr), 32'h00);
        chk("c1_first_data",      32'(f_data), 32'h5A);
        chk("c1_last_addr",       32'(l_addr), 32'h9F);
        chk("c1_last_data",       32'(l_data), 32'hC5);
        chk("c1_strobes",         32'(n_strb), 160);
        chk("c1_active_cycles",   32'(a_cyc), 640);
        chk("c1_active_fall_clk", 32'(fall), 645);
        chk("c1_data_errors",     32'(errs), 0);

        // Echo remap, read-back and bus conflict while active
        cpu_wr(16'hFF46, 8'hE3);
        n = 0;
        while (!src_read_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("e3_src_read_seen", 32'(src_read_en), 1);
        chk("e3_src_addr",      32'(src_addr), 32'hC300);
        rd_probe(16'hFF46, rd, conf);
        chk("e3_ff46_read", 32'(rd), 32'hE3);
        rd_probe(16'hC000, rd, conf);
        chk("conf_rd_c000", 32'(conf), 32'(CONFLICT_EXP));
        chk("unsel_rdata",  32'(rd), 32'hFF);
        rd_probe(16'hFF90, rd, conf);
        chk("conf_rd_ff90", 32'(conf), 0);
        rd_probe(16'hFF80, rd, conf);
        chk("conf_rd_ff80", 32'(conf), 0);
        rd_probe(16'hFFFF, rd, conf);
        chk("conf_rd_ffff", 32'(conf), 32'(CONFLICT_EXP));
        cpu_write_en = 1'b1;
        cpu_addr     = 16'hC000;
        #1;
        chk("conf_wr_c000", 32'(cpu_conflict), 32'(CONFLICT_EXP));
        cpu_write_en = 1'b0;
        cpu_addr     = 16'h0000;
        n = 0;
        while (active && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("e3_finished", 32'(active), 0);
        rd_probe(16'hC000, rd, conf);
        chk("conf_idle_c000", 32'(conf), 0);

        // Restart at byte 50 with a new page
        cpu_wr(16'hFF46, 8'hC1);
        wait_we(8'd49, "rs_reach_49");
        @(negedge clk);
        cpu_wr(16'hFF46, 8'hD0);
        watch_restart(8'hA5, l_old, gap, n_new, l_new, f_new, drop, errs);
        chk("rs_last_old_addr",  32'(l_old), 32'h32);
        chk("rs_restart_gap",    32'(gap), 8);
        chk("rs_first_new_data", 32'(f_new), 32'hA5);
        chk("rs_active_dropped", 32'(drop), 0);
        chk("rs_new_strobes",    32'(n_new), 160);
        chk("rs_last_new_addr",  32'(l_new), 32'h9F);
        chk("rs_data_errors",    32'(errs), 0);

        // Delay expiry on the same clk as the last-byte write
        cpu_wr(16'hFF46, 8'hC1);
        wait_we(8'h9E, "co_reach_9e");
        cpu_wr(16'hFF46, 8'hD0);
        watch_restart(8'hA5, l_old, gap, n_new, l_new, f_new, drop, errs);
        chk("co_last_old_addr",  32'(l_old), 32'h9F);
        chk("co_restart_gap",    32'(gap), 8);
        chk("co_active_dropped", 32'(drop), 0);
        chk("co_new_strobes",    32'(n_new), 160);
        chk("co_data_errors",    32'(errs), 0);

        // Reset during byte 80
        cpu_wr(16'hFF46, 8'hC1);
        wait_we(8'h4F, "rst_reach_79");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_active", 32'(active), 0);
        chk("mid_rst_oam_we", 32'(oam_we), 0);
        rd_probe(16'hFF46, rd, conf);
        chk("mid_rst_ff46", 32'(rd), 32'h00);
        reset = 1'b0;
        n_strb = 0;
        a_cyc  = 0;
        for (int i = 0; i < 700; i++) begin
            if (oam_we) n_strb++;
            if (active) a_cyc++;
            @(negedge clk);
        end
        chk("post_rst_strobes", 32'(n_strb), 0);
        chk("post_rst_active",  32'(a_cyc), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
